// File: rtl/ats21_pkg.sv
// Shared definitions for the ATS21 command receiver: opcodes, widths and queue depth.
package ats21_pkg;

  localparam int unsigned InstrW    = 32;
  localparam int unsigned HalfW     = 16;
  localparam int unsigned FifoDepth = 2;
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);

  typedef enum logic [2:0] {
    OpNop      = 3'b000,
    OpSetClk   = 3'b001,
    OpBcEn     = 3'b010,
    OpMode     = 3'b011,
    OpRsvd     = 3'b100,
    OpSetAlarm = 3'b101,
    OpSetCntdn = 3'b110,
    OpAtEn     = 3'b111
  } opcode_e;

  typedef enum logic {StIdle, StWord2} cap_state_e;

  // NOP is dropped silently and RSVD is dropped with an error; everything else is queued.
  function automatic logic op_enqueues(input opcode_e op);
    return (op != OpNop) && (op != OpRsvd);
  endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// Small show-ahead FIFO; an enqueue while full is accepted only alongside a dequeue.
module ats21_cmd_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enq_i,
  input  logic [Width-1:0] data_i,
  input  logic             deq_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_enq, do_deq;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    do_deq  = deq_i && !empty_o;
    do_enq  = enq_i && (!full_o || do_deq);
    count_d = count_q;
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_enq) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_deq) rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ats21_cmd_rx.sv
// Two-client instruction receiver: captures split 32-bit words, filters by opcode,
// queues per client and hands commands to the core round-robin.
module ats21_cmd_rx
  import ats21_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [HalfW-1:0]  ctrlA,
  input  logic [HalfW-1:0]  ctrlB,
  output logic              ready,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_client,
  output logic [2:0]        cmd_op,
  output logic [InstrW-1:0] cmd_word,
  output logic              err
);

  cap_state_e       state_q;
  logic [HalfW-1:0] upper_a_q, upper_b_q;
  logic             err_q, err_d;
  logic             rr_b_q;       // 1: B is favoured on the next contested transfer
  logic             lock_q, lock_b_q;

  logic [InstrW-1:0] word_a, word_b, head_a, head_b, head_sel;
  opcode_e           op_a, op_b;
  logic              in_word2, enq_a, enq_b, deq_a, deq_b, drop_a, drop_b;
  logic              full_a, full_b, empty_a, empty_b, sel_b, xfer;
  logic [CntW-1:0]   cnt_a, cnt_b;

  always_comb begin
    in_word2 = (state_q == StWord2);
    word_a   = {upper_a_q, ctrlA};
    word_b   = {upper_b_q, ctrlB};
    op_a     = opcode_e'(word_a[InstrW-1 -: 3]);
    op_b     = opcode_e'(word_b[InstrW-1 -: 3]);
    enq_a    = in_word2 && op_enqueues(op_a);
    enq_b    = in_word2 && op_enqueues(op_b);

    // A presented but unaccepted command keeps its slot so the outputs stay stable.
    sel_b     = lock_q ? lock_b_q : (!empty_b && (empty_a || rr_b_q));
    cmd_valid = !empty_a || !empty_b;
    xfer      = cmd_valid && cmd_ready;
    deq_a     = xfer && !sel_b;
    deq_b     = xfer && sel_b;

    drop_a = enq_a && full_a && !deq_a;
    drop_b = enq_b && full_b && !deq_b;
    err_d  = (in_word2 && (req || op_a == OpRsvd || op_b == OpRsvd)) || drop_a || drop_b;

    head_sel   = sel_b ? head_b : head_a;
    cmd_word   = cmd_valid ? head_sel : '0;
    cmd_op     = cmd_word[InstrW-1 -: 3];
    cmd_client = cmd_valid && sel_b;
    ready      = (cnt_a < CntW'(FifoDepth)) && (cnt_b < CntW'(FifoDepth));
  end

  assign err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      upper_a_q <= '0;
      upper_b_q <= '0;
      err_q     <= 1'b0;
      rr_b_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_b_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      unique case (state_q)
        StIdle: if (req) begin
          upper_a_q <= ctrlA;
          upper_b_q <= ctrlB;
          state_q   <= StWord2;
        end
        StWord2: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (xfer) begin
        rr_b_q <= !sel_b;
        lock_q <= 1'b0;
      end else if (cmd_valid) begin
        lock_q   <= 1'b1;
        lock_b_q <= sel_b;
      end
    end
  end

  ats21_cmd_fifo #(.Width(InstrW), .Depth(FifoDepth)) u_fifo_a (
    .clk_i   (clk),
    .rst_i   (reset),
    .enq_i   (enq_a),
    .data_i  (word_a),
    .deq_i   (deq_a),
    .head_o  (head_a),
    .full_o  (full_a),
    .empty_o (empty_a),
    .count_o (cnt_a)
  );

  ats21_cmd_fifo #(.Width(InstrW), .Depth(FifoDepth)) u_fifo_b (
    .clk_i   (clk),
    .rst_i   (reset),
    .enq_i   (enq_b),
    .data_i  (word_b),
    .deq_i   (deq_b),
    .head_o  (head_b),
    .full_o  (full_b),
    .empty_o (empty_b),
    .count_o (cnt_b)
  );

endmodule

// File: tb/tb_ats21_cmd_rx.sv
// Bench for ats21_cmd_rx: directed scenarios plus random traffic against a queue-level model.
module tb_ats21_cmd_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [15:0] ctrlA = '0, ctrlB = '0;
  logic        cmd_ready = 1'b0;
  logic        ready, cmd_valid, cmd_client, err;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_word;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] qa[$], qb[$];
  bit          m_rr_b, m_held, m_held_b, m_word2, m_err;
  logic [15:0] m_ua, m_ub;

  always #5 clk = ~clk;

  ats21_cmd_rx dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ctrlA      (ctrlA),
    .ctrlB      (ctrlB),
    .ready      (ready),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_client (cmd_client),
    .cmd_op     (cmd_op),
    .cmd_word   (cmd_word),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    m_rr_b = 0; m_held = 0; m_held_b = 0; m_word2 = 0; m_err = 0;
  endtask

  // One clock cycle: starts and ends just after a falling edge.
  task automatic step(input bit r, input logic [15:0] a, input logic [15:0] b, input bit rdy);
    bit          mv, sb, nerr, popa, popb;
    int          sa, sz_b;
    logic [31:0] exp_word, wa, wb;
    req = r; ctrlA = a; ctrlB = b; cmd_ready = rdy;
    #1;
    mv = (qa.size() > 0) || (qb.size() > 0);
    if (m_held) sb = m_held_b;
    else        sb = (qb.size() > 0) && ((qa.size() == 0) || m_rr_b);
    exp_word = !mv ? 32'h0 : (sb ? qb[0] : qa[0]);
    chk("cmd_valid", {31'b0, cmd_valid}, {31'b0, mv});
    chk("ready", {31'b0, ready}, {31'b0, (qa.size() < 2) && (qb.size() < 2)});
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("cmd_word", cmd_word, exp_word);
    chk("cmd_op", {29'b0, cmd_op}, {29'b0, exp_word[31:29]});
    chk("cmd_client", {31'b0, cmd_client}, {31'b0, mv && sb});

    sa = qa.size(); sz_b = qb.size(); popa = 0; popb = 0;
    if (mv && rdy) begin
      if (sb) begin void'(qb.pop_front()); popb = 1; end
      else    begin void'(qa.pop_front()); popa = 1; end
      m_rr_b = !sb;
      m_held = 0;
    end else if (mv) begin
      m_held = 1; m_held_b = sb;
    end
    nerr = 0;
    if (m_word2) begin
      nerr = r;
      wa = {m_ua, a};
      wb = {m_ub, b};
      if (wa[31:29] == 3'd4) nerr = 1;
      else if (wa[31:29] != 3'd0) begin
        if (sa == 2 && !popa) nerr = 1; else qa.push_back(wa);
      end
      if (wb[31:29] == 3'd4) nerr = 1;
      else if (wb[31:29] != 3'd0) begin
        if (sz_b == 2 && !popb) nerr = 1; else qb.push_back(wb);
      end
      m_word2 = 0;
    end else if (r) begin
      m_ua = a; m_ub = b; m_word2 = 1;
    end
    @(posedge clk);
    m_err = nerr;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse raised between clock edges.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    model_clear();
    #1;
    chk({tag, "_valid"}, {31'b0, cmd_valid}, 32'h0);
    chk({tag, "_ready"}, {31'b0, ready}, 32'h1);
    chk({tag, "_err"}, {31'b0, err}, 32'h0);
    chk({tag, "_client"}, {31'b0, cmd_client}, 32'h0);
    chk({tag, "_op"}, {29'b0, cmd_op}, 32'h0);
    chk({tag, "_word"}, cmd_word, 32'h0);
    @(posedge clk);
    @(negedge clk);
    req = 0; ctrlA = '0; ctrlB = '0;
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    model_clear();
    #1;
    chk("rst_valid", {31'b0, cmd_valid}, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h1);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_word", cmd_word, 32'h0);
    chk("rst_op", {29'b0, cmd_op}, 32'h0);
    chk("rst_client", {31'b0, cmd_client}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Both clients SET_CLK in one pair: A first, then B.
    step(1, 16'h2000, 16'h2240, 0);
    step(0, 16'h0000, 16'h0000, 0);
    chk("s1_a_word", cmd_word, 32'h2000_0000);
    chk("s1_a_client", {31'b0, cmd_client}, 32'h0);
    chk("s1_a_op", {29'b0, cmd_op}, 32'h1);
    step(0, 16'h0, 16'h0, 1);
    chk("s1_b_word", cmd_word, 32'h2240_0000);
    chk("s1_b_client", {31'b0, cmd_client}, 32'h1);
    step(0, 16'h0, 16'h0, 1);
    chk("s1_empty", {31'b0, cmd_valid}, 32'h0);

    // A SET_ALARM with B NOP.
    step(1, 16'hA000, 16'h0000, 0);
    step(0, 16'h0014, 16'h0000, 0);
    chk("s2_word", cmd_word, 32'hA000_0014);
    chk("s2_op", {29'b0, cmd_op}, 32'h5);
    chk("s2_client", {31'b0, cmd_client}, 32'h0);
    chk("s2_err", {31'b0, err}, 32'h0);
    step(0, 16'h0, 16'h0, 1);
    chk("s2_no_b", {31'b0, cmd_valid}, 32'h0);

    // Backpressure: third pair overflows A.
    step(1, 16'h2000, 16'h0, 0); step(0, 16'h0001, 16'h0, 0);
    chk("s3_ready1", {31'b0, ready}, 32'h1);
    step(1, 16'h2000, 16'h0, 0); step(0, 16'h0002, 16'h0, 0);
    chk("s3_ready0", {31'b0, ready}, 32'h0);
    step(1, 16'h2000, 16'h0, 0); step(0, 16'h0003, 16'h0, 0);
    chk("s3_drop_err", {31'b0, err}, 32'h1);
    step(0, 16'h0, 16'h0, 0);
    chk("s3_first", cmd_word, 32'h2000_0001);
    step(0, 16'h0, 16'h0, 1);
    chk("s3_second", cmd_word, 32'h2000_0002);
    step(0, 16'h0, 16'h0, 1);
    chk("s3_done", {31'b0, cmd_valid}, 32'h0);

    // Reserved opcode, then req held across WORD2.
    step(1, 16'h8000, 16'h0, 1); step(0, 16'h0000, 16'h0, 1);
    chk("s4_rsvd_err", {31'b0, err}, 32'h1);
    chk("s4_no_cmd", {31'b0, cmd_valid}, 32'h0);
    step(1, 16'h2000, 16'h0, 0); step(1, 16'h0005, 16'h0, 0);
    chk("s4_req_err", {31'b0, err}, 32'h1);
    step(0, 16'h0, 16'h0, 0);
    chk("s4_err_clear", {31'b0, err}, 32'h0);
    chk("s4_word", cmd_word, 32'h2000_0005);
    step(0, 16'h0, 16'h0, 1);
    step(0, 16'h0, 16'h0, 1);
    chk("s4_no_extra", {31'b0, cmd_valid}, 32'h0);

    // Reset during WORD2 discards the partial capture.
    step(1, 16'h2000, 16'h0, 0);
    ctrlA = 16'h0000;
    do_reset("s5_rst");
    step(0, 16'h0, 16'h0, 1);
    step(0, 16'h0, 16'h0, 1);
    chk("s5_valid", {31'b0, cmd_valid}, 32'h0);
    chk("s5_ready", {31'b0, ready}, 32'h1);

    // Random traffic; later phase stalls the consumer more often.
    for (int i = 0; i < 600; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra[15:13] = 3'd0;
      if ($urandom_range(0, 3) == 0) rb[15:13] = 3'd0;
      step($urandom_range(0, 2) != 0, ra, rb,
           (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      if (i == 450) do_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ats21_cmd_rx.md
ATS21_CMD_RX -- requirements
Module: ats21_cmd_rx

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port req, input, 1, high for one cycle marks the first (upper) instruction word on ctrlA/ctrlB.
REQ-004 SHALL have port ctrlA, input, 16, client A instruction word: upper half on req cycle, lower half next cycle.
REQ-005 SHALL have port ctrlB, input, 16, client B instruction word, same timing as ctrlA.
REQ-006 SHALL have port ready, output, 1, high when both client queues have at least one free entry.
REQ-007 SHALL have port cmd_valid, output, 1, decoded command available at cmd_* outputs.
REQ-008 SHALL have port cmd_ready, input, 1, core accepts the command; transfer when cmd_valid and cmd_ready are both high.
REQ-009 SHALL have port cmd_client, output, 1, source of the command: 0 = A, 1 = B.
REQ-010 SHALL have port cmd_op, output, 3, opcode, equal to word bits [31:29].
REQ-011 SHALL have port cmd_word, output, 32, full assembled instruction {upper, lower}.
REQ-012 SHALL have port err, output, 1, one-cycle pulse on a dropped instruction or protocol violation.

Function
REQ-013 SHALL implement capture FSM states IDLE and WORD2.
- IDLE: req=1 latches ctrlA/ctrlB as upper halves, then moves to WORD2.
- WORD2: latches lower halves, assembles both 32-bit words, then returns to IDLE unconditionally.
REQ-014 SHALL pulse err when req=1 in WORD2; that req is ignored (it does not start a capture). Maximum rate is one instruction pair per 2 cycles.
REQ-015 SHALL decode per client in the WORD2 cycle:
- opcode 000 (NOP): discarded silently.
- opcode 100 (reserved): discarded with err pulse.
- opcodes 001, 010, 011, 101, 110, 111: enqueued to that client's queue at the end of the WORD2 cycle.
REQ-016 SHALL give each client a 2-entry FIFO. Enqueue to a full FIFO is allowed only if that FIFO is dequeued in the same cycle; otherwise the instruction is dropped with err, and the other client's instruction is unaffected.
REQ-017 SHALL drive ready combinationally from the registered FIFO counts: ready = (countA<2) and (countB<2).
REQ-018 SHALL present FIFO heads show-ahead; cmd_valid = either head non-empty; cmd_* SHALL hold stable while cmd_valid=1 and cmd_ready=0.
REQ-019 SHALL arbitrate round-robin when both heads are valid: the winner flips after each transfer, with A favoured first after reset. A lone non-empty queue SHALL always win.
REQ-020 SHALL have latency from the WORD2 cycle to cmd_valid of 1 cycle when the queue was empty.
REQ-021 SHALL pulse err at most once per cycle, even when several error causes coincide.
REQ-022 SHALL preserve FIFO order per client; no reordering within a client.

Reset
REQ-023 SHALL, on reset assertion and independent of clk, return the FSM to IDLE, empty both FIFOs, and set the round-robin pointer to A.
REQ-024 SHALL hold reset values cmd_valid=0, err=0, ready=1, cmd_client=0, cmd_op=0, cmd_word=0.
REQ-025 SHALL, if reset asserts in WORD2, discard the partial capture and never enqueue it.

Structure
REQ-026 SHALL take from shared package ats21_pkg: opcode enum (NOP, SET_CLK, BC_EN, MODE, RSVD, SET_ALARM, SET_CNTDN, AT_EN), the instruction width 32, the half width 16, and the FIFO depth 2.
REQ-027 SHALL instantiate sub-module ats21_cmd_fifo (32-bit, depth 2, show-ahead, full/empty/count) once per client.

Verification
REQ-028 SHALL cover: A=0x2000_0000, B=0x2240_0000 in one req pair -> two commands on consecutive accepts: A 0x2000_0000 op 001, then B 0x2240_0000 op 001.
REQ-029 SHALL cover: A=0xA000_0014, B=0x0000_0000 -> only A appears (op 101, cmd_word 0xA000_0014); no B command; err=0.
REQ-030 SHALL cover: cmd_ready=0 and three A-only SET_CLK pairs -> ready falls after the second pair; the third pair is dropped with err=1; releasing cmd_ready yields exactly two commands in order.
REQ-031 SHALL cover: A upper 0x8000 (op 100) -> err pulse, no command; req held 2 cycles -> err in WORD2 and no extra capture.
REQ-032 SHALL cover: reset asserted mid-WORD2 with A=0x2000_0000 -> no command after release; ready=1; cmd_valid=0.
